fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares the single-port frame memory (512 x 6-bit RGB pixel words) between two requesters: the SPI pixel-write path from the Pi and the LED-matrix refresh read path.
- Buffers incoming pixel writes in a small FIFO and gives refresh reads priority.
- A starvation counter forces a write slot so that queued SPI writes always drain.
- Sits between the SPI receiver/pixel formatter and the frame memory, replacing the direct write hookup.

Parameters:
- ADDR_W, 9, pixel address width (32x16 panel).
- DATA_W, 6, pixel word width ({RGB top, RGB bottom}).
- WQ_DEPTH, 4, write FIFO depth (power of 2).
- STARVE_LIMIT, 8, consecutive denied write cycles before a write is forced.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  pixel write request from the SPI side.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- wr_ready  out  1  FIFO can accept a write.
- rd_req  in  1  refresh read request; held until rd_valid.
- rd_addr  in  ADDR_W  read address; stable while rd_req is high.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DATA_W  registered read pixel.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe.
- wq_count  out  3  FIFO occupancy (0..WQ_DEPTH).
- overflow_err  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, wq_count=0, starve counter=0, state=IDLE. rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata and overflow_err are all 0. Inputs are ignored while reset=0.
- Reset mid-operation: an in-flight read is abandoned (no rd_valid) and queued writes are lost.
- wr_ready = (wq_count < WQ_DEPTH), combinational. A pop in the same cycle does not raise wr_ready.
- Push: wr_valid & wr_ready. wr_valid & !wr_ready drops the write and sets overflow_err, which is cleared only by reset.
- Read FSM:
  - IDLE: grant a read if rd_req, unless a write is forced. A read grant drives mem_en=1, mem_we=0, mem_addr=rd_addr; go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into rd_data at the clock edge ending this cycle; go to RD_DONE.
  - RD_DONE: rd_valid=1 for this one cycle; go to IDLE. The requester drops rd_req in this cycle. rd_req seen in RD_DONE is not a new request.
  - Read latency: grant in cycle N gives rd_valid in cycle N+2.
- Write grant: the memory port is free this cycle (state RD_WAIT or RD_DONE, or IDLE with no read granted) and the FIFO is non-empty. It drives mem_en=1, mem_we=1, mem_addr/mem_wdata from the FIFO head and pops one entry. At most one memory access per cycle.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no write is granted.
  - Clears on any write grant or when the FIFO is empty.
  - At STARVE_LIMIT, the next IDLE cycle grants the FIFO head instead of a pending read. The read is granted the following cycle.
- Idle cycles (no grant): mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- Writes land in FIFO order. Reads do not snoop the FIFO, so a read may return stale data for an address still queued (accepted display behaviour).
- Simultaneous push and pop: allowed; wq_count is unchanged.

Test Plan:
1. Reset, then a single write (addr 0x005, data 0x2A) with no reads -> one cycle later mem_en=1, mem_we=1, mem_addr=0x005, mem_wdata=0x2A; wq_count returns to 0.
2. rd_req with rd_addr 0x010 while memory returns 0x15 -> mem_en=1/mem_we=0 at cycle N, rd_valid=1 and rd_data=0x15 at N+2; single pulse.
3. Five back-to-back wr_valid cycles while rd_req is continuously re-asserted -> wr_ready falls at wq_count=4; the 5th write is dropped and overflow_err=1; all 4 queued writes reach memory in order.
4. Continuous reads with 1 queued write -> the write issues in RD_WAIT/RD_DONE slots; the starve counter never reaches 8; no read is delayed.
5. Force starvation by stubbing free slots so only IDLE grants exist -> after 8 denied cycles the write is granted in IDLE, the read follows one cycle later, and rd_valid arrives at grant+2.
6. Assert reset in RD_WAIT with 2 writes queued -> no rd_valid; wq_count=0; all outputs 0; normal operation resumes after release.

Source files
------------

// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the frame-memory port arbiter and its surroundings:
// SPI pixel-write handshake, refresh-read handshake, frame-memory port and
// status. The arbiter uses the slave view; the environment uses master.
interface fb_port_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 6,
   parameter int CNT_W  = 3
);
   // SPI pixel-write side
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   // LED refresh read side
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   // Single-port frame memory
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Status
   logic [CNT_W-1:0]  wq_count;
   logic              overflow_err;

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
      output wr_ready, rd_valid, rd_data, mem_en, mem_we, mem_addr,
             mem_wdata, wq_count, overflow_err
   );

   modport master (
      output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
      input  wr_ready, rd_valid, rd_data, mem_en, mem_we, mem_addr,
             mem_wdata, wq_count, overflow_err
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// Frame-memory port arbiter. Refresh reads win the single memory port;
// SPI pixel writes are queued in a small FIFO and drained in the free slots
// of a read (RD_WAIT / RD_DONE) or in idle cycles. A starvation counter
// forces the FIFO head out in IDLE if writes have been denied too long.
module fb_port_arbiter #(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 6,
   parameter int WQ_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8,
   // When 0, queued writes may only use IDLE cycles (the RD_WAIT/RD_DONE
   // slots are withheld), so the starvation path is the only way past a
   // continuous read stream.
   parameter bit FREE_SLOTS   = 1'b1
) (
   input logic                clk,
   input logic                reset,
   fb_port_arbiter_if.slave   bus
);

   localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(WQ_DEPTH + 1);
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(WQ_DEPTH);
   localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;

   logic [ADDR_W-1:0] fifo_addr_q [WQ_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_d [WQ_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [WQ_DEPTH];
   logic [DATA_W-1:0] fifo_data_d [WQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              overflow_q, overflow_d;

   logic              fifo_empty_s;
   logic              fifo_full_s;
   logic              force_wr_s;
   logic              push_s;
   logic              drop_s;
   logic              rd_grant_s;
   logic              wr_grant_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic [DATA_W-1:0] head_data_s;

   assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
   assign fifo_full_s  = (count_q >= DEPTH_CNT);
   assign force_wr_s   = (starve_q >= STARVE_MAX);
   assign head_addr_s  = fifo_addr_q[rd_ptr_q];
   assign head_data_s  = fifo_data_q[rd_ptr_q];

   // A write that arrives while the FIFO is full is dropped, never stalled.
   assign push_s = reset && bus.wr_valid && !fifo_full_s;
   assign drop_s = reset && bus.wr_valid && fifo_full_s;

   // Port arbitration and read FSM next state; nothing is granted in reset.
   always_comb begin
      state_d    = state_q;
      rd_grant_s = 1'b0;
      wr_grant_s = 1'b0;
      if (reset) begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty_s && force_wr_s) begin
                  wr_grant_s = 1'b1;
               end else if (bus.rd_req) begin
                  rd_grant_s = 1'b1;
                  state_d    = ST_RD_WAIT;
               end else if (!fifo_empty_s) begin
                  wr_grant_s = 1'b1;
               end else begin
                  wr_grant_s = 1'b0;
               end
            end
            ST_RD_WAIT: begin
               state_d    = ST_RD_DONE;
               wr_grant_s = FREE_SLOTS && !fifo_empty_s;
            end
            ST_RD_DONE: begin
               // rd_req is still high here but belongs to the finished read.
               state_d    = ST_IDLE;
               wr_grant_s = FREE_SLOTS && !fifo_empty_s;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = ST_IDLE;
      end
   end

   // Write FIFO storage, pointers and occupancy.
   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push_s) begin
         fifo_addr_d[wr_ptr_q] = bus.wr_addr;
         fifo_data_d[wr_ptr_q] = bus.wr_data;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (wr_grant_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, wr_grant_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Starvation counter: counts cycles a non-empty FIFO is refused the port.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty_s || wr_grant_s) begin
         starve_d = {ST_W{1'b0}};
      end else if (starve_q < STARVE_MAX) begin
         starve_d = starve_q + ST_W'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Memory address/data mux; the bus keeps its last value on idle cycles.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (wr_grant_s) begin
         mem_addr_d  = head_addr_s;
         mem_wdata_d = head_data_s;
      end else if (rd_grant_s) begin
         mem_addr_d  = bus.rd_addr;
      end else begin
         mem_addr_d  = mem_addr_q;
      end
   end

   // Read data capture and sticky overflow flag.
   always_comb begin
      rd_data_d  = rd_data_q;
      overflow_d = overflow_q | drop_s;
      if (state_q == ST_RD_WAIT) begin
         rd_data_d = bus.mem_rdata;
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // State register for the FSM, FIFO, counters and output holding registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         for (int i = 0; i < WQ_DEPTH; i++) begin
            fifo_addr_q[i] <= {ADDR_W{1'b0}};
            fifo_data_q[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         starve_q    <= {ST_W{1'b0}};
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         rd_data_q   <= {DATA_W{1'b0}};
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_data_q   <= rd_data_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.wr_ready     = !fifo_full_s;
   assign bus.mem_en       = rd_grant_s | wr_grant_s;
   assign bus.mem_we       = wr_grant_s;
   assign bus.mem_addr     = mem_addr_d;
   assign bus.mem_wdata    = mem_wdata_d;
   assign bus.rd_valid     = (state_q == ST_RD_DONE);
   assign bus.rd_data      = rd_data_q;
   assign bus.wq_count     = count_q;
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter. Instance A is the production
// configuration; instance B withholds the read free slots so queued writes
// can only leave through IDLE cycles (fills the FIFO, exercises starvation).
module tb_fb_port_arbiter;

   logic clk;
   logic reset;

   fb_port_arbiter_if #(.ADDR_W(9), .DATA_W(6), .CNT_W(3)) busa ();
   fb_port_arbiter_if #(.ADDR_W(9), .DATA_W(6), .CNT_W(3)) busb ();

   fb_port_arbiter #(.ADDR_W(9), .DATA_W(6), .WQ_DEPTH(4), .STARVE_LIMIT(8),
                     .FREE_SLOTS(1'b1)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (busa.slave)
   );

   fb_port_arbiter #(.ADDR_W(9), .DATA_W(6), .WQ_DEPTH(4), .STARVE_LIMIT(8),
                     .FREE_SLOTS(1'b0)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (busb.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0]  mem_a [512];
   logic [5:0]  mem_b [512];
   logic [14:0] log_b [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame memory models: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (busa.mem_en) begin
         if (busa.mem_we) mem_a[busa.mem_addr] <= busa.mem_wdata;
         else             busa.mem_rdata <= mem_a[busa.mem_addr];
      end
      if (busb.mem_en) begin
         if (busb.mem_we) mem_b[busb.mem_addr] <= busb.mem_wdata;
         else             busb.mem_rdata <= mem_b[busb.mem_addr];
      end
   end

   // Record the order in which instance B writes reach memory.
   always @(negedge clk) begin
      if (busb.mem_en && busb.mem_we) log_b.push_back({busb.mem_addr, busb.mem_wdata});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int   denied;
      logic found;
      logic [14:0] exp_e;

      reset = 1'b0;
      busa.wr_valid = 1'b0; busa.wr_addr = 9'h000; busa.wr_data = 6'h00;
      busa.rd_req   = 1'b0; busa.rd_addr = 9'h000;
      busb.wr_valid = 1'b0; busb.wr_addr = 9'h000; busb.wr_data = 6'h00;
      busb.rd_req   = 1'b0; busb.rd_addr = 9'h000;

      // Reset state
      @(negedge clk);
      check("rst_mem_en",   32'(busa.mem_en), 32'd0);
      check("rst_mem_we",   32'(busa.mem_we), 32'd0);
      check("rst_mem_addr", 32'(busa.mem_addr), 32'd0);
      check("rst_wdata",    32'(busa.mem_wdata), 32'd0);
      check("rst_rd_valid", 32'(busa.rd_valid), 32'd0);
      check("rst_rd_data",  32'(busa.rd_data), 32'd0);
      check("rst_wq_count", 32'(busa.wq_count), 32'd0);
      check("rst_overflow", 32'(busa.overflow_err), 32'd0);
      check("rst_wr_ready", 32'(busa.wr_ready), 32'd1);
      step();
      reset = 1'b1;
      step();

      // 1: single write, granted the cycle after the push
      busa.wr_valid = 1'b1; busa.wr_addr = 9'h005; busa.wr_data = 6'h2A;
      @(negedge clk);
      check("t1_push_en", 32'(busa.mem_en), 32'd0);
      step();
      busa.wr_valid = 1'b0;
      @(negedge clk);
      check("t1_en",    32'(busa.mem_en), 32'd1);
      check("t1_we",    32'(busa.mem_we), 32'd1);
      check("t1_addr",  32'(busa.mem_addr), 32'h005);
      check("t1_wdata", 32'(busa.mem_wdata), 32'h2A);
      check("t1_cnt1",  32'(busa.wq_count), 32'd1);
      step();
      @(negedge clk);
      check("t1_cnt0",  32'(busa.wq_count), 32'd0);
      check("t1_idle",  32'(busa.mem_en), 32'd0);
      check("t1_hold",  32'(busa.mem_addr), 32'h005);
      step();

      // 2: preload 0x15 at 0x010 through the write path, then read it
      busa.wr_valid = 1'b1; busa.wr_addr = 9'h010; busa.wr_data = 6'h15;
      step();
      busa.wr_valid = 1'b0;
      step();
      busa.rd_req = 1'b1; busa.rd_addr = 9'h010;
      @(negedge clk);
      check("t2_en",   32'(busa.mem_en), 32'd1);
      check("t2_we",   32'(busa.mem_we), 32'd0);
      check("t2_addr", 32'(busa.mem_addr), 32'h010);
      check("t2_v0",   32'(busa.rd_valid), 32'd0);
      step();
      @(negedge clk);
      check("t2_v1",   32'(busa.rd_valid), 32'd0);
      step();
      busa.rd_req = 1'b0;
      @(negedge clk);
      check("t2_v2",   32'(busa.rd_valid), 32'd1);
      check("t2_data", 32'(busa.rd_data), 32'h15);
      step();
      @(negedge clk);
      check("t2_pulse", 32'(busa.rd_valid), 32'd0);
      step();

      // 4: continuous reads with one queued write using a free slot
      busa.rd_req = 1'b1; busa.rd_addr = 9'h005;
      busa.wr_valid = 1'b1; busa.wr_addr = 9'h006; busa.wr_data = 6'h11;
      @(negedge clk);
      check("t4_rd0_en", 32'(busa.mem_en), 32'd1);
      check("t4_rd0_we", 32'(busa.mem_we), 32'd0);
      step();
      busa.wr_valid = 1'b0;
      @(negedge clk);
      check("t4_wr_we",   32'(busa.mem_en & busa.mem_we), 32'd1);
      check("t4_wr_addr", 32'(busa.mem_addr), 32'h006);
      step();
      @(negedge clk);
      check("t4_v0",    32'(busa.rd_valid), 32'd1);
      check("t4_d0",    32'(busa.rd_data), 32'h2A);
      step();
      @(negedge clk);
      check("t4_rd1_en", 32'(busa.mem_en), 32'd1);
      check("t4_rd1_we", 32'(busa.mem_we), 32'd0);
      step();
      step();
      @(negedge clk);
      check("t4_v1",    32'(busa.rd_valid), 32'd1);
      check("t4_cnt",   32'(busa.wq_count), 32'd0);
      busa.rd_req = 1'b0;
      step();

      // 3: five back-to-back writes into B under continuous reads
      busb.rd_req = 1'b1; busb.rd_addr = 9'h101;
      for (int i = 0; i < 5; i++) begin
         busb.wr_valid = 1'b1;
         busb.wr_addr  = 9'h100 + 9'(i);
         busb.wr_data  = 6'h20 + 6'(i);
         @(negedge clk);
         check($sformatf("t3_cnt%0d", i),   32'(busb.wq_count), 32'(i));
         check($sformatf("t3_ready%0d", i), 32'(busb.wr_ready), (i < 4) ? 32'd1 : 32'd0);
         step();
      end
      busb.wr_valid = 1'b0;
      @(negedge clk);
      check("t3_overflow", 32'(busb.overflow_err), 32'd1);
      check("t3_full",     32'(busb.wq_count), 32'd4);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         step();
         @(negedge clk);
         if (busb.wq_count == 3'd0) begin
            found = 1'b1;
            break;
         end
      end
      check("t3_drained", 32'(found), 32'd1);
      check("t3_nwrites", 32'(log_b.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         exp_e = {9'h100 + 9'(i), 6'h20 + 6'(i)};
         check($sformatf("t3_order%0d", i),
               (i < log_b.size()) ? 32'(log_b[i]) : 32'hFFFF_FFFF, 32'(exp_e));
      end
      step();

      // 5: starvation forcing on B (rd_req still continuously high)
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busb.mem_en && !busb.mem_we) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("t5_sync", 32'(found), 32'd1);
      busb.wr_valid = 1'b1; busb.wr_addr = 9'h1FF; busb.wr_data = 6'h3F;
      step();
      busb.wr_valid = 1'b0;
      denied = 0;
      found  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busb.mem_en && busb.mem_we) begin
            found = 1'b1;
            break;
         end
         if (busb.wq_count != 3'd0) denied++;
         step();
      end
      check("t5_granted", 32'(found), 32'd1);
      check("t5_denied",  32'(denied), 32'd8);
      check("t5_addr",    32'(busb.mem_addr), 32'h1FF);
      check("t5_wdata",   32'(busb.mem_wdata), 32'h3F);
      step();
      @(negedge clk);
      check("t5_rd_en", 32'(busb.mem_en), 32'd1);
      check("t5_rd_we", 32'(busb.mem_we), 32'd0);
      step();
      step();
      @(negedge clk);
      check("t5_valid", 32'(busb.rd_valid), 32'd1);
      check("t5_data",  32'(busb.rd_data), 32'h21);
      step();

      // 6: reset in RD_WAIT with two writes queued on B
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busb.mem_en && !busb.mem_we) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("t6_sync", 32'(found), 32'd1);
      step();
      step();
      busb.wr_valid = 1'b1; busb.wr_addr = 9'h0AA; busb.wr_data = 6'h0A;
      step();
      busb.wr_addr = 9'h0AB; busb.wr_data = 6'h0B;
      step();
      busb.wr_valid = 1'b0;
      @(negedge clk);
      check("t6_pre_cnt", 32'(busb.wq_count), 32'd2);
      check("t6_pre_v",   32'(busb.rd_valid), 32'd0);
      reset = 1'b0;
      #1;
      check("t6_cnt",   32'(busb.wq_count), 32'd0);
      check("t6_en",    32'(busb.mem_en), 32'd0);
      check("t6_we",    32'(busb.mem_we), 32'd0);
      check("t6_addr",  32'(busb.mem_addr), 32'd0);
      check("t6_wdata", 32'(busb.mem_wdata), 32'd0);
      check("t6_rdata", 32'(busb.rd_data), 32'd0);
      check("t6_ovf",   32'(busb.overflow_err), 32'd0);
      check("t6_a_addr", 32'(busa.mem_addr), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t6_in_rst_v%0d", k), 32'(busb.rd_valid | busb.mem_en), 32'd0);
      end
      busb.rd_req = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t6_post_v%0d", k), 32'(busb.rd_valid), 32'd0);
         step();
      end

      // Resume: A read of 0x006, B write of 0x0CC
      busa.rd_req = 1'b1; busa.rd_addr = 9'h006;
      busb.wr_valid = 1'b1; busb.wr_addr = 9'h0CC; busb.wr_data = 6'h2C;
      @(negedge clk);
      check("t6_res_a_en", 32'(busa.mem_en & ~busa.mem_we), 32'd1);
      step();
      busb.wr_valid = 1'b0;
      @(negedge clk);
      check("t6_res_b_we",   32'(busb.mem_en & busb.mem_we), 32'd1);
      check("t6_res_b_addr", 32'(busb.mem_addr), 32'h0CC);
      step();
      busa.rd_req = 1'b0;
      @(negedge clk);
      check("t6_res_a_v", 32'(busa.rd_valid), 32'd1);
      check("t6_res_a_d", 32'(busa.rd_data), 32'h11);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
